inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage of the RV32I core; consumer end of the program-counter interface (P_PC/P_VALID in, STALL out).
- Accepts one PC per cycle and issues a single-beat instruction read per PC over a req/ack memory port.
- Buffers returned instructions with their PC in an in-order queue for the decode stage.
- Handles FLUSH by discarding queued and in-flight fetches.

Parameters:
DEPTH, 4, fetch queue entries (power of 2, >=2); bounds fetched-plus-outstanding instructions
NOP_INST, 32'h0000_0013, value driven on F_INST when the queue is empty

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-high
P_PC  in  32  PC from program counter
P_VALID  in  1  P_PC valid
FLUSH  in  1  redirect; discard all fetch state (same cycle PC loads NEW_PC)
STALL  out  1  to program counter; hold P_PC, do not advance
MEM_RREQ  out  1  read request, registered
MEM_RADDR  out  32  read address, registered, word aligned
MEM_RACK  in  1  read data valid / request done (single cycle)
MEM_RDATA  in  32  read data, valid with MEM_RACK
D_STALL  in  1  decode cannot accept
F_VALID  out  1  queue head valid
F_PC  out  32  queue head PC (0 when empty)
F_INST  out  32  queue head instruction (NOP_INST when empty)

Behaviour:
- Reset (async): state IDLE, MEM_RREQ=0, MEM_RADDR=0, queue empty, F_VALID=0, F_PC=0, F_INST=NOP_INST.
- FSM states:
  - IDLE: no read outstanding.
  - REQ: read outstanding, data will be kept.
  - DROP: read outstanding, data will be discarded.
- RES = count + (state!=IDLE), evaluated at cycle start. A pop in the same cycle is not credited.
- accept = P_VALID && !FLUSH && RES<DEPTH && (state==IDLE || (state==REQ && MEM_RACK)).
- STALL = P_VALID && !accept (combinational). STALL=0 when P_VALID=0.
- On accept: MEM_RADDR<={P_PC[31:2],2'b00}, MEM_RREQ<=1, state<=REQ.
  - Latency: accept at edge N gives MEM_RREQ high from cycle N+1.
- MEM_RREQ stays high until the cycle MEM_RACK=1. Requester never withdraws a request.
- REQ with MEM_RACK:
  - push {MEM_RADDR, MEM_RDATA} into the queue.
  - state<=REQ if accept this cycle (back-to-back; one fetch per cycle at 1-cycle memory latency), else IDLE with MEM_RREQ<=0.
- Head output: F_VALID = (count!=0), F_PC/F_INST from the head entry.
  - Empty queue, ack at edge M: F_VALID high from cycle M+1.
- Pop when F_VALID && !D_STALL. Push and pop in the same cycle leave count unchanged.
- Order: strictly in issue order. count never exceeds DEPTH, guaranteed by the RES rule.
- FLUSH (priority over push, pop and accept):
  - Queue cleared at the edge; F_VALID=0 next cycle.
  - REQ && !MEM_RACK: state<=DROP, MEM_RREQ held.
  - REQ && MEM_RACK: data discarded, state<=IDLE, MEM_RREQ<=0.
  - IDLE stays IDLE. DROP stays DROP.
- DROP:
  - No accept.
  - On MEM_RACK: data discarded, MEM_RREQ<=0, state<=IDLE; new PCs accepted from the next cycle.
- Reset mid-request: outputs clear immediately. Memory side must tolerate the dropped request.

Optional Feature:
Macro FETCH_MISALIGN_CHK_EN.
- Defined:
  - Extra output F_MISALIGN (1 bit) qualifies the queue head.
  - An accepted P_PC with P_PC[1:0]!=0 issues no memory read. Instead it pushes {P_PC, NOP_INST, misalign=1} directly.
  - The direct push requires state==IDLE (or the REQ ack cycle with no ack push) and RES<DEPTH.
  - F_MISALIGN=0 for normal entries.
- Not defined: no F_MISALIGN port; low PC bits are forced to zero on MEM_RADDR and F_PC carries P_PC unmodified.

Test Plan:
1. Reset; P_VALID=1, P_PC=0x2000_0000; memory acks 1 cycle after req with 0x0000_0093 -> MEM_RREQ=1, MEM_RADDR=0x2000_0000 at N+1; F_VALID=1, F_PC=0x2000_0000, F_INST=0x0000_0093 the cycle after ack; STALL=0 throughout.
2. Stream 0x2000_0000/04/08, ack every cycle -> MEM_RREQ continuously high; addresses advance one per cycle; F_PC sequence 00,04,08 in order.
3. D_STALL=1 held, DEPTH=4 -> after 4 accepts, STALL=1 with no 5th request; D_STALL=0 -> entries pop 00..0C in order, then fetch resumes.
4. FLUSH while a request is outstanding, ack delayed 3 cycles -> F_VALID=0 next cycle; MEM_RREQ held until ack; acked data never appears; STALL=1 during DROP; then P_PC=0x2000_0100 fetched normally.
5. RST pulsed mid-cycle during REQ with 2 entries queued -> MEM_RREQ=0, F_VALID=0, F_INST=0x0000_0013 immediately, before the next edge.
6. FETCH_MISALIGN_CHK_EN defined, P_PC=0x2000_0002 -> no MEM_RREQ; F_VALID=1, F_MISALIGN=1, F_INST=0x0000_0013, F_PC=0x2000_0002.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one single-beat memory read per accepted PC, results queued in order for decode.
// Optional macro FETCH_MISALIGN_CHK_EN adds F_MISALIGN and turns misaligned PCs into queued NOP entries.
module inst_fetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] P_PC,
   input  logic        P_VALID,
   input  logic        FLUSH,
   output logic        STALL,
   output logic        MEM_RREQ,
   output logic [31:0] MEM_RADDR,
   input  logic        MEM_RACK,
   input  logic [31:0] MEM_RDATA,
   input  logic        D_STALL,
   output logic        F_VALID,
   output logic [31:0] F_PC,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic        F_MISALIGN,
`endif
   output logic [31:0] F_INST
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t        state_q, state_d;
   logic          rreq_q, rreq_d;
   logic [31:0]   raddr_q, raddr_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   fifo_inst_q [DEPTH];

   logic [PW+1:0] res;
   logic          ack_kept;
   logic          slot_free;
   logic          misaligned;
   logic          accept;
   logic          mem_accept;
   logic          direct_push;
   logic          ack_push;
   logic          push;
   logic          pop;
   logic [31:0]   push_pc_d;
   logic [31:0]   push_inst_d;

`ifdef FETCH_MISALIGN_CHK_EN
   logic          fifo_mis_q [DEPTH];
   assign misaligned = (P_PC[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Reservation counts the outstanding read so queue space exists for every returning beat.
   assign res       = {1'b0, count_q} + {{(PW+1){1'b0}}, (state_q != S_IDLE)};
   assign ack_kept  = (state_q == S_REQ) && MEM_RACK;
   assign slot_free = (state_q == S_IDLE) || ack_kept;

   // A misaligned PC pushes directly, so it cannot share the cycle with an ack push.
   assign accept      = P_VALID && !FLUSH && (res < (PW+2)'(DEPTH)) && slot_free &&
                        !(misaligned && (state_q != S_IDLE));
   assign mem_accept  = accept && !misaligned;
   assign direct_push = accept && misaligned;
   assign ack_push    = ack_kept && !FLUSH;
   assign push        = ack_push || direct_push;
   assign pop         = F_VALID && !D_STALL && !FLUSH;
   assign push_pc_d   = ack_push ? req_pc_q : P_PC;
   assign push_inst_d = ack_push ? MEM_RDATA : NOP_INST;

   assign STALL     = P_VALID && !accept;
   assign MEM_RREQ  = rreq_q;
   assign MEM_RADDR = raddr_q;
   assign F_VALID   = (count_q != '0);
   assign F_PC      = F_VALID ? fifo_pc_q[rd_ptr_q] : 32'h0;
   assign F_INST    = F_VALID ? fifo_inst_q[rd_ptr_q] : NOP_INST;
`ifdef FETCH_MISALIGN_CHK_EN
   assign F_MISALIGN = F_VALID && fifo_mis_q[rd_ptr_q];
`endif

   always_comb begin
      state_d  = state_q;
      rreq_d   = rreq_q;
      raddr_d  = raddr_q;
      req_pc_d = req_pc_q;
      case (state_q)
         S_IDLE: ;
         S_REQ: begin
            if (MEM_RACK) begin
               state_d = S_IDLE;
               rreq_d  = 1'b0;
            end else if (FLUSH) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (MEM_RACK) begin
               state_d = S_IDLE;
               rreq_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            rreq_d  = 1'b0;
         end
      endcase
      // A new request overrides the ack-cycle return to IDLE (back-to-back fetch).
      if (mem_accept) begin
         state_d  = S_REQ;
         rreq_d   = 1'b1;
         raddr_d  = {P_PC[31:2], 2'b00};
         req_pc_d = P_PC;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         rreq_q   <= 1'b0;
         raddr_q  <= 32'h0;
         req_pc_q <= 32'h0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rreq_q   <= rreq_d;
         raddr_q  <= raddr_d;
         req_pc_q <= req_pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: heads are masked by count_q.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= push_pc_d;
         fifo_inst_q[wr_ptr_q] <= push_inst_d;
`ifdef FETCH_MISALIGN_CHK_EN
         fifo_mis_q[wr_ptr_q]  <= direct_push;
`endif
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios then randomized traffic against a queue-based model.
module tb_inst_fetch;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        CLK, RST;
   logic [31:0] P_PC;
   logic        P_VALID, FLUSH, STALL, MEM_RREQ, MEM_RACK, D_STALL, F_VALID;
   logic [31:0] MEM_RADDR, MEM_RDATA, F_PC, F_INST;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        F_MISALIGN;
`endif

   int checks   = 0;
   int failures = 0;

   inst_fetch dut (
      .CLK(CLK), .RST(RST), .P_PC(P_PC), .P_VALID(P_VALID), .FLUSH(FLUSH), .STALL(STALL),
      .MEM_RREQ(MEM_RREQ), .MEM_RADDR(MEM_RADDR), .MEM_RACK(MEM_RACK), .MEM_RDATA(MEM_RDATA),
      .D_STALL(D_STALL), .F_VALID(F_VALID), .F_PC(F_PC),
`ifdef FETCH_MISALIGN_CHK_EN
      .F_MISALIGN(F_MISALIGN),
`endif
      .F_INST(F_INST)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Reference model: fetched entries in a queue, at most one outstanding read.
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];
   bit          q_mis[$];
   bit          m_out, m_drop;
   logic [31:0] m_addr, m_pc;
   bit          last_stall;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return ((a ^ 32'h2000_0000) << 8) | 32'h0000_0093;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_pc.delete(); q_inst.delete(); q_mis.delete();
      m_out = 0; m_drop = 0; m_addr = 32'h0; m_pc = 32'h0; last_stall = 0;
   endtask

   task automatic step(input logic pv, input logic [31:0] pc, input logic ds,
                       input logic fl, input logic ack);
      bit room, slot, mis, acc, ack_eff, pop;
      @(negedge CLK);
      ack_eff   = ack && m_out;
      P_VALID   = pv; P_PC = pc; D_STALL = ds; FLUSH = fl; MEM_RACK = ack_eff;
      MEM_RDATA = ack_eff ? mem_fn(m_addr) : $urandom;
      #1;
      room = (q_pc.size() + int'(m_out)) < DEPTH;
      slot = !m_out || (!m_drop && ack_eff);
      acc  = pv && !fl && room && slot;
`ifdef FETCH_MISALIGN_CHK_EN
      mis = (pc[1:0] != 2'b00);
      if (mis && m_out) acc = 0;
`else
      mis = 0;
`endif
      last_stall = pv && !acc;
      chk("stall", STALL, last_stall);
      chk("rreq", MEM_RREQ, m_out);
      chk("raddr", MEM_RADDR, m_addr);
      chk("f_valid", F_VALID, q_pc.size() != 0);
      chk("f_pc", F_PC, (q_pc.size() != 0) ? q_pc[0] : 32'h0);
      chk("f_inst", F_INST, (q_pc.size() != 0) ? q_inst[0] : NOP);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("f_misalign", F_MISALIGN, (q_pc.size() != 0) ? q_mis[0] : 1'b0);
`endif
      $display("step pv=%0b pc=%h ds=%0b fl=%0b ack=%0b stall=%0b f_valid=%0b f_pc=%h f_inst=%h",
               pv, pc, ds, fl, ack_eff, STALL, F_VALID, F_PC, F_INST);
      // Advance the model across the coming rising edge.
      if (fl) begin
         q_pc.delete(); q_inst.delete(); q_mis.delete();
         if (m_out) begin
            if (ack_eff) m_out = 0;
            else         m_drop = 1;
         end
      end else begin
         pop = (q_pc.size() != 0) && !ds;
         if (pop) begin
            void'(q_pc.pop_front()); void'(q_inst.pop_front()); void'(q_mis.pop_front());
         end
         if (m_out && ack_eff) begin
            if (!m_drop) begin
               q_pc.push_back(m_pc); q_inst.push_back(mem_fn(m_addr)); q_mis.push_back(0);
            end
            m_out = 0; m_drop = 0;
         end
         if (acc) begin
            if (mis) begin
               q_pc.push_back(pc); q_inst.push_back(NOP); q_mis.push_back(1);
            end else begin
               m_out = 1; m_drop = 0; m_addr = {pc[31:2], 2'b00}; m_pc = pc;
            end
         end
      end
   endtask

   initial begin
      logic [31:0] pc, rnd;
      logic        pv, fl;
      P_VALID = 0; P_PC = 0; FLUSH = 0; MEM_RACK = 0; MEM_RDATA = 0; D_STALL = 0;
      RST = 1;
      model_reset();
      @(negedge CLK); #1;
      chk("rst_rreq", MEM_RREQ, 1'b0);
      chk("rst_raddr", MEM_RADDR, 32'h0);
      chk("rst_fvalid", F_VALID, 1'b0);
      chk("rst_fpc", F_PC, 32'h0);
      chk("rst_finst", F_INST, NOP);
      RST = 0;

      // Single fetch with one-cycle memory.
      step(1, 32'h2000_0000, 0, 0, 0);
      step(0, 32'h0, 0, 0, 1);
      chk("t1_rreq", MEM_RREQ, 1'b1);
      chk("t1_raddr", MEM_RADDR, 32'h2000_0000);
      step(0, 32'h0, 0, 0, 0);
      chk("t1_fvalid", F_VALID, 1'b1);
      chk("t1_fpc", F_PC, 32'h2000_0000);
      chk("t1_finst", F_INST, 32'h0000_0093);

      // Back-to-back stream.
      step(1, 32'h2000_0000, 0, 0, 0);
      step(1, 32'h2000_0004, 0, 0, 1);
      chk("t2_rreq0", MEM_RREQ, 1'b1);
      step(1, 32'h2000_0008, 0, 0, 1);
      chk("t2_rreq1", MEM_RREQ, 1'b1);
      chk("t2_raddr1", MEM_RADDR, 32'h2000_0004);
      step(0, 32'h0, 0, 0, 1);
      chk("t2_raddr2", MEM_RADDR, 32'h2000_0008);
      repeat (4) step(0, 32'h0, 0, 0, 0);

      // Decode stalled: four reservations fill the queue.
      pc = 32'h2000_0000;
      for (int i = 0; i < 7; i++) begin
         step(1, pc, 1, 0, 1);
         if (!last_stall) pc = pc + 32'h4;
      end
      chk("t3_stall", STALL, 1'b1);
      chk("t3_norreq", MEM_RREQ, 1'b0);
      chk("t3_head", F_PC, 32'h2000_0000);
      for (int i = 0; i < 8; i++) begin
         step(1, pc, 0, 0, 1);
         if (!last_stall) pc = pc + 32'h4;
      end
      repeat (4) step(0, 32'h0, 0, 0, 1);

      // Flush with a slow read outstanding.
      step(1, 32'h2000_0040, 0, 0, 0);
      step(0, 32'h0, 0, 1, 0);
      step(1, 32'h2000_0100, 0, 0, 0);
      chk("t4_fvalid", F_VALID, 1'b0);
      chk("t4_drop_stall", STALL, 1'b1);
      chk("t4_rreq_held", MEM_RREQ, 1'b1);
      step(1, 32'h2000_0100, 0, 0, 0);
      step(1, 32'h2000_0100, 0, 0, 1);
      chk("t4_ack_stall", STALL, 1'b1);
      step(1, 32'h2000_0100, 0, 0, 0);
      chk("t4_accept", STALL, 1'b0);
      step(0, 32'h0, 0, 0, 1);
      step(0, 32'h0, 0, 0, 0);
      chk("t4_fpc", F_PC, 32'h2000_0100);

      // Asynchronous reset mid-request with entries queued.
      step(1, 32'h2000_0200, 1, 0, 0);
      step(1, 32'h2000_0204, 1, 0, 1);
      step(1, 32'h2000_0208, 1, 0, 1);
      step(0, 32'h0, 1, 0, 0);
      #1 RST = 1;
      #1;
      chk("t5_rreq", MEM_RREQ, 1'b0);
      chk("t5_fvalid", F_VALID, 1'b0);
      chk("t5_finst", F_INST, NOP);
      chk("t5_fpc", F_PC, 32'h0);
      model_reset();
      @(negedge CLK);
      P_VALID = 0; D_STALL = 0; MEM_RACK = 0;
      @(negedge CLK);
      RST = 0;

`ifdef FETCH_MISALIGN_CHK_EN
      step(1, 32'h2000_0002, 0, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      chk("t6_norreq", MEM_RREQ, 1'b0);
      chk("t6_fmis", F_MISALIGN, 1'b1);
      chk("t6_fpc", F_PC, 32'h2000_0002);
      chk("t6_finst", F_INST, NOP);
      step(0, 32'h0, 0, 0, 0);
`endif

      // Randomized traffic; a stalled PC is held until taken or flushed.
      pv = 0; pc = 32'h2000_0000; last_stall = 0;
      for (int i = 0; i < 3000; i++) begin
         fl = ($urandom_range(0, 99) < 3);
         if (!last_stall || fl) begin
            pv  = ($urandom_range(0, 3) != 0);
            rnd = 32'($urandom_range(0, 1023));
            pc  = 32'h2000_0000 + (rnd << 2);
            if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
         end
         step(pv, pc, ($urandom_range(0, 2) == 0), fl, ($urandom_range(0, 1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
